// File: rtl/rcrc_pkg.sv
// Shared constants, state encoding and the CRC-15 step for the receive-CRC sequencer.
package rcrc_pkg;

    localparam int              CRC_W      = 15;
    localparam logic [CRC_W-1:0] CRC_POLY  = 15'h4599;
    localparam int              RXCRC_BITS = 15;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CALC    = 3'd1,
        RXCRC   = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } rcrc_state_e;

    // One mod-2 division step of the CAN CRC-15; the x^15 term is implicit.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
        logic fb;
        fb = b ^ c[CRC_W-1];
        return {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    endfunction

endpackage

// File: rtl/rcrc_seq_if.sv
// Bit-stream inputs and CRC/verdict outputs of the receive-CRC sequencer.
// Stats outputs frame_cnt/err_cnt exist only when RCRC_SEQ_STATS_EN is defined.
interface rcrc_seq_if;
    import rcrc_pkg::*;

    // bit_valid is a level strobe with no ready: a bit is consumed on the first
    // cycle bit_valid is high while the qualifier is armed; the source must hold it
    // low for MIN_GAP cycles before presenting the next bit.
    logic             start;
    logic             bit_valid;
    logic             bit_in;
    logic             crc_field;
    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] rx_crc;
    logic             crc_ok;
    logic             crc_err;
    logic             strobe_err;
    logic             busy;
    rcrc_state_e      state_dbg;
`ifdef RCRC_SEQ_STATS_EN
    logic [15:0]      frame_cnt;
    logic [7:0]       err_cnt;
`endif

    modport master (
        output start, bit_valid, bit_in, crc_field,
`ifdef RCRC_SEQ_STATS_EN
        input  frame_cnt, err_cnt,
`endif
        input  crc_q, rx_crc, crc_ok, crc_err, strobe_err, busy, state_dbg
    );

    modport slave (
        input  start, bit_valid, bit_in, crc_field,
`ifdef RCRC_SEQ_STATS_EN
        output frame_cnt, err_cnt,
`endif
        output crc_q, rx_crc, crc_ok, crc_err, strobe_err, busy, state_dbg
    );

endinterface

// File: rtl/rcrc_edge_q.sv
// Edge qualifier: turns the level bit strobe into one accept pulse per bit and
// flags rising edges that arrive before MIN_GAP low cycles have elapsed.
module rcrc_edge_q #(
    parameter int MIN_GAP = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic bit_valid,
    output logic accept,
    output logic drop
);

    localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    logic          armed;
    logic          bit_valid_d;
    logic [GW-1:0] gap_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            armed       <= 1'b1;
            bit_valid_d <= 1'b0;
            gap_cnt     <= '0;
        end else begin
            bit_valid_d <= bit_valid;
            if (bit_valid) begin
                gap_cnt <= '0;
                armed   <= 1'b0;
            end else if (gap_cnt >= GW'(MIN_GAP - 1)) begin
                armed   <= 1'b1;
            end else begin
                gap_cnt <= gap_cnt + GW'(1);
            end
        end
    end

    assign accept = bit_valid && armed;
    assign drop   = bit_valid && !bit_valid_d && !armed;

endmodule

// File: rtl/rcrc_seq.sv
// Receive-CRC sequencer: runs CRC-15 over SOF..data, captures the received CRC field
// and issues a registered verdict. Define RCRC_SEQ_STATS_EN for frame/error counters.
module rcrc_seq
    import rcrc_pkg::*;
#(
    parameter int MIN_GAP = 1
) (
    input  logic       clock,
    input  logic       reset,
    rcrc_seq_if.slave  bus
);

    rcrc_state_e      state;
    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] rx_crc;
    logic [3:0]       bit_cnt;
    logic             crc_ok;
    logic             crc_err;
    logic             strobe_err;
    logic             busy;
    logic             accept;
    logic             drop;

    rcrc_edge_q #(.MIN_GAP(MIN_GAP)) u_edge_q (
        .clock     (clock),
        .reset     (reset),
        .bit_valid (bus.bit_valid),
        .accept    (accept),
        .drop      (drop)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            crc_q      <= '0;
            rx_crc     <= '0;
            bit_cnt    <= '0;
            crc_ok     <= 1'b0;
            crc_err    <= 1'b0;
            strobe_err <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (drop) strobe_err <= 1'b1;
            // start outranks everything, including a bit accepted in the same cycle.
            if (bus.start) begin
                state      <= CALC;
                crc_q      <= '0;
                rx_crc     <= '0;
                bit_cnt    <= '0;
                crc_ok     <= 1'b0;
                crc_err    <= 1'b0;
                strobe_err <= 1'b0;
                busy       <= 1'b1;
            end else begin
                case (state)
                    CALC: if (accept) begin
                        if (!bus.crc_field) begin
                            crc_q <= crc_step(crc_q, bus.bit_in);
                        end else begin
                            rx_crc  <= {rx_crc[CRC_W-2:0], bus.bit_in};
                            bit_cnt <= 4'd1;
                            state   <= RXCRC;
                        end
                    end
                    RXCRC: if (accept) begin
                        if (!bus.crc_field) begin
                            crc_err <= 1'b1;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            rx_crc  <= {rx_crc[CRC_W-2:0], bus.bit_in};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'(RXCRC_BITS - 1)) state <= COMPARE;
                        end
                    end
                    COMPARE: begin
                        crc_ok  <= (crc_q == rx_crc);
                        crc_err <= (crc_q != rx_crc);
                        busy    <= 1'b0;
                        state   <= DONE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.crc_q      = crc_q;
    assign bus.rx_crc     = rx_crc;
    assign bus.crc_ok     = crc_ok;
    assign bus.crc_err    = crc_err;
    assign bus.strobe_err = strobe_err;
    assign bus.busy       = busy;
    assign bus.state_dbg  = state;

`ifdef RCRC_SEQ_STATS_EN
    logic        frame_err;
    logic        verdict_evt;
    logic        fail_evt;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    // A verdict is either the COMPARE result or a framing error in RXCRC.
    assign frame_err   = (state == RXCRC) && accept && !bus.crc_field;
    assign verdict_evt = !bus.start && ((state == COMPARE) || frame_err);
    assign fail_evt    = !bus.start && (((state == COMPARE) && (crc_q != rx_crc)) || frame_err);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (verdict_evt && (frame_cnt != 16'hFFFF)) frame_cnt <= frame_cnt + 16'd1;
            if (fail_evt && (err_cnt != 8'hFF))         err_cnt   <= err_cnt + 8'd1;
        end
    end

    assign bus.frame_cnt = frame_cnt;
    assign bus.err_cnt   = err_cnt;
`endif

endmodule

// File: tb/tb_rcrc_seq.sv
// Directed bench for rcrc_seq: a verdict scoreboard fed by the drivers and drained
// by a negedge monitor, plus direct checks of state, CRC and strobe behaviour.
module tb_rcrc_seq;
    import rcrc_pkg::*;

    logic clock;
    logic reset;
    int   cyc;
    int   chk_cnt;
    int   pass_cnt;
    logic v_prev;
    logic [47:0] exp_q[$];

    rcrc_seq_if bus ();
    rcrc_seq_if bus2 ();

    rcrc_seq #(.MIN_GAP(1)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    rcrc_seq #(.MIN_GAP(2)) u_dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2.slave)
    );

    // Clock and cycle counter.
    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send_bit(input logic b, input logic f);
        bus.bit_valid = 1'b1;
        bus.bit_in    = b;
        bus.crc_field = f;
        tick();
        bus.bit_valid = 1'b0;
        tick();
    endtask

    // Shifts a 15-bit CRC field MSB first; the verdict is due 2 cycles after the 15th bit.
    task automatic send_crc(input logic [14:0] v, input logic [31:0] e);
        for (int i = 14; i >= 0; i--) begin
            if (i == 0) exp_q.push_back({16'(cyc + 2), e});
            send_bit(v[i], 1'b1);
        end
    endtask

    // Monitor: each new verdict is compared against the head of the queue.
    always @(negedge clock) begin
        logic [47:0] e;
        if (reset) begin
            v_prev = 1'b0;
        end else begin
            if ((bus.crc_ok || bus.crc_err) && !v_prev) begin
                if (exp_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL verdict_unexpected: got ok=%0b err=%0b, expected no verdict",
                             bus.crc_ok, bus.crc_err);
                end else begin
                    e = exp_q.pop_front();
                    check_val("verdict", {bus.crc_ok, bus.crc_err, bus.rx_crc, bus.crc_q}, e[31:0]);
                    check_val("verdict_cycle", 32'(cyc), 32'(e[47:32]));
                end
            end
            v_prev = bus.crc_ok || bus.crc_err;
        end
    end

    initial begin
        cyc = 0; chk_cnt = 0; pass_cnt = 0; v_prev = 1'b0;
        reset = 1'b1;
        bus.start = 1'b0;  bus.bit_valid = 1'b0;  bus.bit_in = 1'b0;  bus.crc_field = 1'b0;
        bus2.start = 1'b0; bus2.bit_valid = 1'b0; bus2.bit_in = 1'b0; bus2.crc_field = 1'b0;
        repeat (2) tick();
        check_val("reset_outputs", 32'({bus.crc_ok, bus.crc_err, bus.strobe_err, bus.busy, bus.crc_q, bus.rx_crc}), 32'd0);
        check_val("reset_state", 32'(bus.state_dbg), 32'(IDLE));
        reset = 1'b0;
        tick();

        // Bits in IDLE are ignored.
        send_bit(1'b1, 1'b0);
        check_val("idle_ignore", 32'({bus.state_dbg, bus.crc_q}), 32'({IDLE, 15'h0000}));

        // Basic match.
        do_start();
        check_val("start_calc", 32'({bus.state_dbg, bus.busy}), 32'({CALC, 1'b1}));
        send_bit(1'b1, 1'b0);
        check_val("data_bit1", 32'(bus.crc_q), 32'h4599);
        send_crc(15'h4599, {1'b1, 1'b0, 15'h4599, 15'h4599});
        tick();
        check_val("done_state", 32'({bus.state_dbg, bus.busy}), 32'({DONE, 1'b0}));
        send_bit(1'b0, 1'b1);
        check_val("done_hold", 32'({bus.crc_ok, bus.rx_crc}), 32'({1'b1, 15'h4599}));

        // Mismatch.
        do_start();
        check_val("start_clears", 32'({bus.crc_ok, bus.crc_err}), 32'd0);
        send_bit(1'b1, 1'b0);
        send_crc(15'h4598, {1'b0, 1'b1, 15'h4598, 15'h4599});

        // Zero data.
        do_start();
        send_bit(1'b0, 1'b0);
        check_val("zero_data", 32'(bus.crc_q), 32'h0000);
        send_crc(15'h0000, {1'b1, 1'b0, 15'h0000, 15'h0000});

        // Held strobe: five high cycles give one update.
        do_start();
        bus.bit_valid = 1'b1; bus.bit_in = 1'b1; bus.crc_field = 1'b0;
        repeat (5) tick();
        bus.bit_valid = 1'b0;
        tick();
        check_val("held_strobe", 32'(bus.crc_q), 32'h4599);
        send_bit(1'b1, 1'b0);
        check_val("second_step", 32'(bus.crc_q), 32'h0B32);
        check_val("no_strobe_err", 32'(bus.strobe_err), 32'd0);

        // Framing error after 7 CRC bits.
        do_start();
        send_bit(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) send_bit(((i % 2) == 0), 1'b1);
        exp_q.push_back({16'(cyc + 1), 1'b0, 1'b1, 15'h0055, 15'h4599});
        send_bit(1'b0, 1'b0);
        tick();
        check_val("framing_idle", 32'({bus.state_dbg, bus.busy}), 32'({IDLE, 1'b0}));

        // Restart mid-RXCRC, with start coinciding with an accepted bit.
        do_start();
        send_bit(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
        check_val("rxcrc_partial", 32'({bus.state_dbg, bus.rx_crc}), 32'({RXCRC, 15'h001F}));
        bus.start = 1'b1; bus.bit_valid = 1'b1; bus.bit_in = 1'b1; bus.crc_field = 1'b1;
        tick();
        bus.start = 1'b0; bus.bit_valid = 1'b0;
        tick();
        check_val("restart_regs", 32'({bus.crc_ok, bus.crc_err, bus.busy, bus.crc_q, bus.rx_crc}), 32'({3'b001, 30'd0}));
        check_val("restart_state", 32'(bus.state_dbg), 32'(CALC));

        // Asynchronous reset between clock edges mid-CALC.
        send_bit(1'b1, 1'b0);
        check_val("pre_reset_crc", 32'(bus.crc_q), 32'h4599);
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        check_val("async_reset_outputs", 32'({bus.crc_ok, bus.crc_err, bus.strobe_err, bus.busy, bus.crc_q, bus.rx_crc}), 32'd0);
        check_val("async_reset_state", 32'(bus.state_dbg), 32'(IDLE));
        #2 reset = 1'b0;
        tick();

        // Fast strobe on the MIN_GAP=2 instance: one low cycle is too short.
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        bus2.bit_valid = 1'b1; bus2.bit_in = 1'b1; bus2.crc_field = 1'b0;
        tick();
        bus2.bit_valid = 1'b0;
        tick();
        bus2.bit_valid = 1'b1;
        tick();
        bus2.bit_valid = 1'b0;
        check_val("fast_drop_crc", 32'(bus2.crc_q), 32'h4599);
        check_val("fast_strobe_err", 32'(bus2.strobe_err), 32'd1);
        repeat (2) tick();
        bus2.bit_valid = 1'b1;
        tick();
        bus2.bit_valid = 1'b0;
        tick();
        check_val("gap_ok_crc", 32'({bus2.strobe_err, bus2.crc_q}), 32'({1'b1, 15'h0B32}));

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check_val("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
